atm_txn_ctrl: RTL and testbench
===============================

ATM_TXN_CTRL -- requirements
Module: atm_txn_ctrl

Interface
REQ-001 SHALL have parameter PIN_W, default 16: PIN width in bits.
REQ-002 SHALL have parameter AMT_W, default 16: amount and balance width in bits.
REQ-003 SHALL have parameter MAX_TRIES, default 3: wrong-PIN attempts before the card is retained; legal range 1..15.
REQ-004 SHALL have parameter TIMEOUT, default 1024: inactivity limit in cycles; legal range >= 2.
REQ-005 SHALL have ports:
- clk  in  1  clock; reset, asynchronous, active-high.
- reset  in  1  asynchronous reset, active-high.
- card_insert  in  1  card-present level.
- card_pin  in  PIN_W  card's stored PIN.
- acct_balance  in  AMT_W  account balance.
- pin_valid  in  1  PIN entry strobe.
- pin_in  in  PIN_W  entered PIN.
- txn_valid  in  1  transaction select strobe.
- txn_type  in  2  00 withdraw, 01 deposit, 10 balance enquiry, 11 reserved.
- txn_amt  in  AMT_W  amount.
- txn_confirm  in  1  confirm strobe.
- cancel  in  1  user abort.
- txn_complete  out  1  one-cycle success pulse.
- txn_failed  out  1  one-cycle failure pulse.
- card_eject  out  1  one-cycle eject pulse.
- card_retain  out  1  one-cycle retain pulse.
- balance_out  out  AMT_W  session balance.
- state_o  out  3  current state encoding.

Function
REQ-006 SHALL implement states IDLE, PIN_WAIT, SELECT, CONFIRM; state_o SHALL equal the state register.
REQ-007 IDLE: a rising edge of card_insert SHALL move to PIN_WAIT, capture card_pin and acct_balance, and clear the try counter; a level-high card_insert without an edge SHALL be ignored.
REQ-008 PIN_WAIT: pin_valid with pin_in == captured PIN SHALL move to SELECT.
REQ-009 PIN_WAIT: pin_valid with a mismatch SHALL increment the try counter; the MAX_TRIES-th mismatch SHALL move to IDLE and pulse card_retain and txn_failed.
REQ-010 SELECT: txn_valid SHALL capture txn_type and txn_amt and move to CONFIRM; txn_type 11 SHALL pulse txn_failed and remain in SELECT.
REQ-011 CONFIRM, on txn_confirm:
- withdraw with amt <= balance: subtract.
- deposit without overflow of AMT_W: add.
- balance enquiry: no change.
- On success, pulse txn_complete.
- On withdraw amt > balance, or deposit carry out, pulse txn_failed with balance unchanged.
- In all cases, pulse card_eject and move to IDLE.
REQ-012 cancel in any non-IDLE state SHALL move to IDLE and pulse card_eject only.
REQ-013 card_insert low in any non-IDLE state SHALL move to IDLE and pulse txn_failed; card_eject SHALL NOT pulse.
REQ-014 Event priority SHALL be: reset > card removal > cancel > timeout > normal transition; only the winning event's pulses SHALL be asserted.
REQ-015 All outputs SHALL be registered; each pulse SHALL assert in the cycle after the triggering input is sampled and last exactly one cycle.
REQ-016 balance_out SHALL reflect the captured balance, update one cycle after a successful transaction, and hold its value in IDLE.

Reset
REQ-017 Reset SHALL force state IDLE, clear the try counter and timer, clear all pulse outputs and balance_out to 0, and clear the card_insert edge register.
REQ-018 Reset asserted mid-session SHALL abandon the session without any pulse.

Configuration
REQ-019 With ATM_TIMEOUT_EN defined, an inactivity counter SHALL reset on entry to a non-IDLE state and on any pin_valid, txn_valid or txn_confirm.
REQ-020 With ATM_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 the block SHALL move to IDLE and pulse txn_failed and card_eject.
REQ-021 Without ATM_TIMEOUT_EN, no timer logic SHALL exist, and non-IDLE states SHALL wait indefinitely.

Structure
REQ-022 A shared package atm_pkg SHALL hold the state enum and the txn_type codes TXN_WITHDRAW, TXN_DEPOSIT, TXN_BALANCE.
REQ-023 The inactivity counter SHALL be a sub-module atm_timeout_timer, instantiated only under ATM_TIMEOUT_EN.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Card insert with PIN 0x1234 and balance 500; pin_in 0x1234; withdraw 200; confirm -> txn_complete and card_eject on the same cycle; balance_out = 300.
- Three wrong PINs (MAX_TRIES=3) -> third attempt pulses card_retain and txn_failed; state IDLE; no card_eject.
- Balance 100; withdraw 150; confirm -> txn_failed and card_eject; balance_out = 100.
- Balance 0xFFF0 (AMT_W=16); deposit 0x20 -> txn_failed; balance_out = 0xFFF0.
- Card removed and cancel in the same cycle in SELECT -> txn_failed only; state IDLE.
- With ATM_TIMEOUT_EN and TIMEOUT=16, idle in PIN_WAIT -> txn_failed and card_eject exactly 16 cycles after entry.

Source files
------------

// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Purpose : Shared types and constants for the ATM transaction controller.
//           Holds the controller state enum and the txn_type codes.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package atm_pkg;

  localparam int unsigned STATE_W = 3;

  // Encoding is visible on state_o, so values are fixed explicitly.
  typedef enum logic [STATE_W-1:0] {
    StIdle    = 3'd0,
    StPinWait = 3'd1,
    StSelect  = 3'd2,
    StConfirm = 3'd3
  } atm_state_e;

  localparam logic [1:0] TXN_WITHDRAW = 2'b00;
  localparam logic [1:0] TXN_DEPOSIT  = 2'b01;
  localparam logic [1:0] TXN_BALANCE  = 2'b10;
  localparam logic [1:0] TXN_RESERVED = 2'b11;

endpackage

// File: rtl/atm_timeout_timer.sv
// ---------------------------------------------------------------------------
// atm_timeout_timer
// Purpose : Inactivity counter. Counts cycles since the last clear and
//           saturates at TIMEOUT-1, where o_expired is asserted.
// Ports   : clk        clock
//           reset      asynchronous reset, active-high
//           i_clear    restart the count from zero
//           o_expired  count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module atm_timeout_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_expired
);

  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits for TIMEOUT >= 2.
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// atm_txn_ctrl
// Purpose : ATM session controller. Detects card insertion, verifies the PIN
//           with a bounded number of attempts, accepts one transaction
//           (withdraw / deposit / balance enquiry), applies it to a session
//           copy of the balance and ejects or retains the card.
// Config  : define ATM_TIMEOUT_EN to add an inactivity timeout
//           (atm_timeout_timer); without it non-idle states wait forever.
// Ports   : clk           clock
//           reset         asynchronous reset, active-high
//           card_insert   card-present level
//           card_pin      card's stored PIN (captured on insertion)
//           acct_balance  account balance (captured on insertion)
//           pin_valid     PIN entry strobe, pin_in holds the entered PIN
//           txn_valid     transaction select strobe with txn_type / txn_amt
//           txn_confirm   confirm strobe
//           cancel        user abort
//           txn_complete  one-cycle success pulse
//           txn_failed    one-cycle failure pulse
//           card_eject    one-cycle eject pulse
//           card_retain   one-cycle retain pulse
//           balance_out   session balance
//           state_o       current state encoding
// ---------------------------------------------------------------------------
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned PIN_W     = 16,
  parameter int unsigned AMT_W     = 16,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               card_insert,
  input  logic [PIN_W-1:0]   card_pin,
  input  logic [AMT_W-1:0]   acct_balance,
  input  logic               pin_valid,
  input  logic [PIN_W-1:0]   pin_in,
  input  logic               txn_valid,
  input  logic [1:0]         txn_type,
  input  logic [AMT_W-1:0]   txn_amt,
  input  logic               txn_confirm,
  input  logic               cancel,
  output logic               txn_complete,
  output logic               txn_failed,
  output logic               card_eject,
  output logic               card_retain,
  output logic [AMT_W-1:0]   balance_out,
  output logic [STATE_W-1:0] state_o
);

  // Elaboration-time legality checks on the configuration.
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("atm_txn_ctrl: MAX_TRIES must be in 1..15");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("atm_txn_ctrl: TIMEOUT must be >= 2");
  end

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  atm_state_e       r_state;
  logic             r_card_q;
  logic [PIN_W-1:0] r_pin;
  logic [AMT_W-1:0] r_balance;
  logic [1:0]       r_txn_type;
  logic [AMT_W-1:0] r_txn_amt;
  logic [3:0]       r_tries;
  logic             r_complete;
  logic             r_failed;
  logic             r_eject;
  logic             r_retain;

  logic             w_card_rise;
  logic             w_active;
  logic             w_removed;
  logic             w_cancel;
  logic             w_timeout;
  logic             w_pin_match;
  logic             w_can_withdraw;
  logic [AMT_W:0]   w_sum;
  logic [AMT_W-1:0] w_diff;

  // The edge register is cleared by reset, so a card already present when
  // reset releases is seen as a fresh insertion.
  assign w_card_rise    = card_insert & ~r_card_q;
  assign w_active       = (r_state != StIdle);
  assign w_removed      = w_active & ~card_insert;
  assign w_cancel       = w_active & cancel;
  assign w_pin_match    = (pin_in == r_pin);
  assign w_can_withdraw = (r_txn_amt <= r_balance);
  assign w_sum          = {1'b0, r_balance} + {1'b0, r_txn_amt};
  assign w_diff         = r_balance - r_txn_amt;

`ifdef ATM_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_expired;

  // Held clear throughout IDLE so the count starts at zero on entry to
  // PIN_WAIT; later state entries are caused by strobes that also clear it.
  assign w_timer_clear = ~w_active | pin_valid | txn_valid | txn_confirm;

  atm_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .o_expired (w_timer_expired)
  );

  assign w_timeout = w_active & w_timer_expired;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_card_q   <= 1'b0;
      r_pin      <= '0;
      r_balance  <= '0;
      r_txn_type <= TXN_WITHDRAW;
      r_txn_amt  <= '0;
      r_tries    <= '0;
      r_complete <= 1'b0;
      r_failed   <= 1'b0;
      r_eject    <= 1'b0;
      r_retain   <= 1'b0;
    end else begin
      r_card_q   <= card_insert;
      r_complete <= 1'b0;
      r_failed   <= 1'b0;
      r_eject    <= 1'b0;
      r_retain   <= 1'b0;

      // Abort events in priority order; only the winner's pulses fire.
      if (w_removed) begin
        r_state  <= StIdle;
        r_failed <= 1'b1;
      end else if (w_cancel) begin
        r_state <= StIdle;
        r_eject <= 1'b1;
      end else if (w_timeout) begin
        r_state  <= StIdle;
        r_failed <= 1'b1;
        r_eject  <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_card_rise) begin
              r_state   <= StPinWait;
              r_pin     <= card_pin;
              r_balance <= acct_balance;
              r_tries   <= '0;
            end
          end

          StPinWait: begin
            if (pin_valid) begin
              if (w_pin_match) begin
                r_state <= StSelect;
              end else begin
                r_tries <= r_tries + 1'b1;
                if (r_tries == LAST_TRY) begin
                  r_state  <= StIdle;
                  r_retain <= 1'b1;
                  r_failed <= 1'b1;
                end
              end
            end
          end

          StSelect: begin
            if (txn_valid) begin
              if (txn_type == TXN_RESERVED) begin
                r_failed <= 1'b1;
              end else begin
                r_txn_type <= txn_type;
                r_txn_amt  <= txn_amt;
                r_state    <= StConfirm;
              end
            end
          end

          StConfirm: begin
            if (txn_confirm) begin
              r_state <= StIdle;
              r_eject <= 1'b1;
              case (r_txn_type)
                TXN_WITHDRAW: begin
                  if (w_can_withdraw) begin
                    r_balance  <= w_diff;
                    r_complete <= 1'b1;
                  end else begin
                    r_failed <= 1'b1;
                  end
                end
                TXN_DEPOSIT: begin
                  // Carry out means the sum does not fit in AMT_W bits.
                  if (w_sum[AMT_W]) begin
                    r_failed <= 1'b1;
                  end else begin
                    r_balance  <= w_sum[AMT_W-1:0];
                    r_complete <= 1'b1;
                  end
                end
                default: begin
                  r_complete <= 1'b1;
                end
              endcase
            end
          end

          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign txn_complete = r_complete;
  assign txn_failed   = r_failed;
  assign card_eject   = r_eject;
  assign card_retain  = r_retain;
  assign balance_out  = r_balance;
  assign state_o      = r_state;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atm_txn_ctrl
// Self-checking bench for atm_txn_ctrl (PIN_W=AMT_W=16, MAX_TRIES=3,
// TIMEOUT=16). Vectors are applied one per cycle; each drive pushes the
// expected outputs to a scoreboard that is popped after the clock edge.
// Pulse field order everywhere: {txn_complete, txn_failed, card_eject,
// card_retain}. States: 0 idle, 1 pin wait, 2 select, 3 confirm.
// ---------------------------------------------------------------------------
module tb_atm_txn_ctrl;

  logic        clk;
  logic        reset;
  logic        card_insert;
  logic [15:0] card_pin;
  logic [15:0] acct_balance;
  logic        pin_valid;
  logic [15:0] pin_in;
  logic        txn_valid;
  logic [1:0]  txn_type;
  logic [15:0] txn_amt;
  logic        txn_confirm;
  logic        cancel;
  logic        txn_complete;
  logic        txn_failed;
  logic        card_eject;
  logic        card_retain;
  logic [15:0] balance_out;
  logic [2:0]  state_o;

  logic [3:0]  w_pulses;
  assign w_pulses = {txn_complete, txn_failed, card_eject, card_retain};

  atm_txn_ctrl #(
    .PIN_W     (16),
    .AMT_W     (16),
    .MAX_TRIES (3),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .card_insert  (card_insert),
    .card_pin     (card_pin),
    .acct_balance (acct_balance),
    .pin_valid    (pin_valid),
    .pin_in       (pin_in),
    .txn_valid    (txn_valid),
    .txn_type     (txn_type),
    .txn_amt      (txn_amt),
    .txn_confirm  (txn_confirm),
    .cancel       (cancel),
    .txn_complete (txn_complete),
    .txn_failed   (txn_failed),
    .card_eject   (card_eject),
    .card_retain  (card_retain),
    .balance_out  (balance_out),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  p;
    logic [15:0] b;
    logic [2:0]  s;
  } exp_t;

  typedef struct {
    string       name;
    logic        c;
    logic [15:0] cp;
    logic [15:0] ab;
    logic        pv;
    logic [15:0] pi;
    logic        tv;
    logic [1:0]  tt;
    logic [15:0] am;
    logic        cf;
    logic        cn;
    logic [3:0]  ep;
    logic [15:0] eb;
    logic [2:0]  es;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [15:0] P = 16'h1234;

  task automatic add(input string nm, input logic c, input logic [15:0] cp,
                     input logic [15:0] ab, input logic pv, input logic [15:0] pi,
                     input logic tv, input logic [1:0] tt, input logic [15:0] am,
                     input logic cf, input logic cn, input logic [3:0] ep,
                     input logic [15:0] eb, input logic [2:0] es);
    vec_t v;
    v.name = nm; v.c = c; v.cp = cp; v.ab = ab; v.pv = pv; v.pi = pi;
    v.tv = tv; v.tt = tt; v.am = am; v.cf = cf; v.cn = cn;
    v.ep = ep; v.eb = eb; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] gp, input logic [15:0] gb,
                       input logic [2:0] gs, input logic [3:0] ep, input logic [15:0] eb,
                       input logic [2:0] es);
    total++;
    if ({gp, gb, gs} !== {ep, eb, es}) begin
      bad++;
      $display("FAIL %s: got pulses=%b bal=%h state=%0d, want pulses=%b bal=%h state=%0d",
               nm, gp, gb, gs, ep, eb, es);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic strobes_off();
    pin_valid = 1'b0; txn_valid = 1'b0; txn_confirm = 1'b0; cancel = 1'b0;
    pin_in = '0; txn_type = '0; txn_amt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    logic seen;

    // Table: withdraw success, level-high card ignored
    add("s1_ins",  1, P, 500,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 500, 1);
    add("s1_pin",  1, P, 500,  1, P, 0, 0, 0,   0, 0, 4'b0000, 500, 2);
    add("s1_sel",  1, P, 500,  0, 0, 1, 0, 200, 0, 0, 4'b0000, 500, 3);
    add("s1_cfm",  1, P, 500,  0, 0, 0, 0, 0,   1, 0, 4'b1010, 300, 0);
    add("s1_lvl",  1, P, 999,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 300, 0);
    add("s1_rem",  0, P, 999,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 300, 0);
    // Three wrong PINs -> retain
    add("s2_ins",  1, P, 500,  0, 0,        0, 0, 0, 0, 0, 4'b0000, 500, 1);
    add("s2_bad1", 1, P, 500,  1, 16'h1111, 0, 0, 0, 0, 0, 4'b0000, 500, 1);
    add("s2_gap",  1, P, 500,  0, 0,        0, 0, 0, 0, 0, 4'b0000, 500, 1);
    add("s2_bad2", 1, P, 500,  1, 16'h1235, 0, 0, 0, 0, 0, 4'b0000, 500, 1);
    add("s2_bad3", 1, P, 500,  1, 16'h0000, 0, 0, 0, 0, 0, 4'b0101, 500, 0);
    add("s2_rem",  0, P, 500,  0, 0,        0, 0, 0, 0, 0, 4'b0000, 500, 0);
    // Try counter restarts per card; cancel ejects only
    add("s2b_ins",  1, P, 700, 0, 0,        0, 0, 0, 0, 0, 4'b0000, 700, 1);
    add("s2b_bad1", 1, P, 700, 1, 16'h4321, 0, 0, 0, 0, 0, 4'b0000, 700, 1);
    add("s2b_bad2", 1, P, 700, 1, 16'h4321, 0, 0, 0, 0, 0, 4'b0000, 700, 1);
    add("s2b_good", 1, P, 700, 1, P,        0, 0, 0, 0, 0, 4'b0000, 700, 2);
    add("s2b_cncl", 1, P, 700, 0, 0,        0, 0, 0, 0, 1, 4'b0010, 700, 0);
    add("s2b_lvl",  1, P, 700, 0, 0,        0, 0, 0, 0, 0, 4'b0000, 700, 0);
    add("s2b_rem",  0, P, 700, 0, 0,        0, 0, 0, 0, 0, 4'b0000, 700, 0);
    // Insufficient funds
    add("s3_ins",  1, P, 100,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 100, 1);
    add("s3_pin",  1, P, 100,  1, P, 0, 0, 0,   0, 0, 4'b0000, 100, 2);
    add("s3_sel",  1, P, 100,  0, 0, 1, 0, 150, 0, 0, 4'b0000, 100, 3);
    add("s3_cfm",  1, P, 100,  0, 0, 0, 0, 0,   1, 0, 4'b0110, 100, 0);
    add("s3_rem",  0, P, 100,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 100, 0);
    // Deposit overflow, then deposit that exactly fits
    add("s4_ins",  1, P, 16'hFFF0, 0, 0, 0, 0, 0,     0, 0, 4'b0000, 16'hFFF0, 1);
    add("s4_pin",  1, P, 16'hFFF0, 1, P, 0, 0, 0,     0, 0, 4'b0000, 16'hFFF0, 2);
    add("s4_sel",  1, P, 16'hFFF0, 0, 0, 1, 1, 16'h20, 0, 0, 4'b0000, 16'hFFF0, 3);
    add("s4_cfm",  1, P, 16'hFFF0, 0, 0, 0, 0, 0,     1, 0, 4'b0110, 16'hFFF0, 0);
    add("s4_rem",  0, P, 16'hFFF0, 0, 0, 0, 0, 0,     0, 0, 4'b0000, 16'hFFF0, 0);
    add("s4b_ins", 1, P, 16'hFFF0, 0, 0, 0, 0, 0,     0, 0, 4'b0000, 16'hFFF0, 1);
    add("s4b_pin", 1, P, 16'hFFF0, 1, P, 0, 0, 0,     0, 0, 4'b0000, 16'hFFF0, 2);
    add("s4b_sel", 1, P, 16'hFFF0, 0, 0, 1, 1, 16'h0F, 0, 0, 4'b0000, 16'hFFF0, 3);
    add("s4b_cfm", 1, P, 16'hFFF0, 0, 0, 0, 0, 0,     1, 0, 4'b1010, 16'hFFFF, 0);
    add("s4b_rem", 0, P, 16'hFFF0, 0, 0, 0, 0, 0,     0, 0, 4'b0000, 16'hFFFF, 0);
    // Reserved type stays in select; balance enquiry completes
    add("s5_ins",  1, P, 250,  0, 0, 0, 0,     0, 0, 0, 4'b0000, 250, 1);
    add("s5_pin",  1, P, 250,  1, P, 0, 0,     0, 0, 0, 4'b0000, 250, 2);
    add("s5_rsv",  1, P, 250,  0, 0, 1, 2'b11, 5, 0, 0, 4'b0100, 250, 2);
    add("s5_enq",  1, P, 250,  0, 0, 1, 2'b10, 5, 0, 0, 4'b0000, 250, 3);
    add("s5_cfm",  1, P, 250,  0, 0, 0, 0,     0, 1, 0, 4'b1010, 250, 0);
    add("s5_rem",  0, P, 250,  0, 0, 0, 0,     0, 0, 0, 4'b0000, 250, 0);
    // Withdraw of the full balance
    add("s6_ins",  1, P, 300,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 300, 1);
    add("s6_pin",  1, P, 300,  1, P, 0, 0, 0,   0, 0, 4'b0000, 300, 2);
    add("s6_sel",  1, P, 300,  0, 0, 1, 0, 300, 0, 0, 4'b0000, 300, 3);
    add("s6_cfm",  1, P, 300,  0, 0, 0, 0, 0,   1, 0, 4'b1010, 0,   0);
    add("s6_rem",  0, P, 300,  0, 0, 0, 0, 0,   0, 0, 4'b0000, 0,   0);
    // Removal and cancel together in select: removal wins
    add("s7_ins",  1, P, 42,   0, 0, 0, 0, 0, 0, 0, 4'b0000, 42, 1);
    add("s7_pin",  1, P, 42,   1, P, 0, 0, 0, 0, 0, 4'b0000, 42, 2);
    add("s7_both", 0, P, 42,   0, 0, 0, 0, 0, 0, 1, 4'b0100, 42, 0);
    // Removal with confirm: no transaction, no eject
    add("s8_ins",  1, P, 42,   0, 0, 0, 0, 0,  0, 0, 4'b0000, 42, 1);
    add("s8_pin",  1, P, 42,   1, P, 0, 0, 0,  0, 0, 4'b0000, 42, 2);
    add("s8_sel",  1, P, 42,   0, 0, 1, 0, 10, 0, 0, 4'b0000, 42, 3);
    add("s8_rcf",  0, P, 42,   0, 0, 0, 0, 0,  1, 0, 4'b0100, 42, 0);
    // Cancel with confirm: cancel wins
    add("s9_ins",  1, P, 42,   0, 0, 0, 0, 0,  0, 0, 4'b0000, 42, 1);
    add("s9_pin",  1, P, 42,   1, P, 0, 0, 0,  0, 0, 4'b0000, 42, 2);
    add("s9_sel",  1, P, 42,   0, 0, 1, 0, 10, 0, 0, 4'b0000, 42, 3);
    add("s9_ccf",  1, P, 42,   0, 0, 0, 0, 0,  1, 1, 4'b0010, 42, 0);
    add("s9_rem",  0, P, 42,   0, 0, 0, 0, 0,  0, 0, 4'b0000, 42, 0);

    reset = 1'b1; card_insert = 1'b0; card_pin = '0; acct_balance = '0;
    strobes_off();
    tick();
    tick();
    check("reset_state", w_pulses, balance_out, state_o, 4'b0000, 16'h0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      card_insert = vecs[i].c; card_pin = vecs[i].cp; acct_balance = vecs[i].ab;
      pin_valid = vecs[i].pv; pin_in = vecs[i].pi;
      txn_valid = vecs[i].tv; txn_type = vecs[i].tt; txn_amt = vecs[i].am;
      txn_confirm = vecs[i].cf; cancel = vecs[i].cn;
      e.name = vecs[i].name; e.p = vecs[i].ep; e.b = vecs[i].eb; e.s = vecs[i].es;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check(e.name, w_pulses, balance_out, state_o, e.p, e.b, e.s);
    end
    @(negedge clk);
    strobes_off();
    card_insert = 1'b0;
    tick();

`ifdef ATM_TIMEOUT_EN
    // Idle in PIN_WAIT: timeout pulses exactly 16 cycles after entry
    @(negedge clk);
    card_insert = 1'b1; card_pin = P; acct_balance = 16'd77;
    tick();
    check_int("to_entry_state", int'(state_o), 1);
    n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      @(negedge clk);
      tick();
      if (w_pulses != 4'b0000) n = k;
    end
    check_int("to_cycles", n, 16);
    check("to_pulse", w_pulses, balance_out, state_o, 4'b0110, 16'd77, 3'd0);
    @(negedge clk);
    card_insert = 1'b0;
    tick();
    // A PIN attempt at cycle 10 restarts the count
    @(negedge clk);
    card_insert = 1'b1;
    tick();
    n = 0;
    for (int k = 1; k <= 60 && n == 0; k++) begin
      @(negedge clk);
      pin_valid = (k == 10);
      pin_in = 16'hBEEF;
      tick();
      if (w_pulses != 4'b0000) n = k;
    end
    check_int("to_restart_cycles", n, 26);
    check("to_restart_pulse", w_pulses, balance_out, state_o, 4'b0110, 16'd77, 3'd0);
    @(negedge clk);
    strobes_off();
    card_insert = 1'b0;
    tick();
`else
    // No timer: PIN_WAIT waits indefinitely
    @(negedge clk);
    card_insert = 1'b1; card_pin = P; acct_balance = 16'd77;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      tick();
      if (w_pulses != 4'b0000) seen = 1'b1;
    end
    check_int("no_to_pulse", int'(seen), 0);
    check_int("no_to_state", int'(state_o), 1);
    @(negedge clk);
    cancel = 1'b1;
    tick();
    check("no_to_cancel", w_pulses, balance_out, state_o, 4'b0010, 16'd77, 3'd0);
    @(negedge clk);
    strobes_off();
    card_insert = 1'b0;
    tick();
`endif

    // Reset mid-session abandons silently
    @(negedge clk);
    card_insert = 1'b1; card_pin = P; acct_balance = 16'd555;
    tick();
    @(negedge clk);
    pin_valid = 1'b1; pin_in = P;
    tick();
    check("rst_pre", w_pulses, balance_out, state_o, 4'b0000, 16'd555, 3'd2);
    @(negedge clk);
    strobes_off();
    reset = 1'b1;
    card_insert = 1'b0;
    #1;
    check("rst_async", w_pulses, balance_out, state_o, 4'b0000, 16'd0, 3'd0);
    tick();
    check("rst_hold", w_pulses, balance_out, state_o, 4'b0000, 16'd0, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rst_after", w_pulses, balance_out, state_o, 4'b0000, 16'd0, 3'd0);
    @(negedge clk);
    card_insert = 1'b1; acct_balance = 16'd9;
    tick();
    check("rst_reinsert", w_pulses, balance_out, state_o, 4'b0000, 16'd9, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
